// File: rtl/instr_feeder_if.sv
// instr_feeder_if: DIN/Run/Done instruction-delivery bundle between an
// instruction source (master, e.g. instr_feeder) and the Processor core (slave).
// The source drives the 16-bit word and its one-cycle Run strobe; the core
// answers with Done when the instruction has completed.
interface instr_feeder_if;
  logic [15:0] DIN;
  logic        Run;
  logic        Done;

  modport master (
    output DIN,
    output Run,
    input  Done
  );

  modport slave (
    input  DIN,
    input  Run,
    output Done
  );
endinterface

// File: rtl/instr_feeder.sv
// instr_feeder: program-memory sequencer feeding the Processor's DIN/Run/Done
// protocol from a small writable program RAM (2**AW words of 16 bits).
//
// Each instruction word is issued with a one-cycle Run pulse; an mvi word is
// followed by its immediate word (without Run) on the next cycle. The sequencer
// then waits for Done, advances pc by 1 (2 for mvi) and issues the next word on
// the same edge that sampled Done. An opcode 111 word, running off the end of
// memory, or an mvi in the last word (no room for its immediate) stops the
// sequencer in HALT until the next start.
//
// pc always names the last instruction actually issued: a fetch that halts
// leaves it untouched, except on start, which always clears it to 0.
//
// Optional feature, selected with macro WATCHDOG_EN: a WAIT-state cycle counter
// that halts with error=1 once TIMEOUT cycles pass without Done. Without the
// macro there is no counter and WAIT waits for Done indefinitely.
module instr_feeder #(
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  Resetn,
  input  logic                  start,
  input  logic                  load_we,
  input  logic [AW-1:0]         load_addr,
  input  logic [15:0]           load_data,
  instr_feeder_if.master        bus,
  output logic                  busy,
  output logic                  halted,
  output logic [AW-1:0]         pc,
  output logic [15:0]           icount,
  output logic                  error
);

  localparam int DEPTH = 2 ** AW;

  localparam logic [2:0]    OP_MVI   = 3'b001;
  localparam logic [2:0]    OP_HALT  = 3'b111;
  localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);
  localparam logic [AW:0]   STEP_ONE = (AW+1)'(1);
  localparam logic [AW:0]   STEP_TWO = (AW+1)'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_HALT
  } state_t;

  // Program RAM (not reset, contents survive Resetn)
  logic [15:0] mem_q [DEPTH];

  // Sequencer state and registered outputs
  state_t        state_q,  state_d;
  logic [15:0]   din_q,    din_d;
  logic          run_q,    run_d;
  logic          busy_q,   busy_d;
  logic          halted_q, halted_d;
  logic [AW-1:0] pc_q,     pc_d;
  logic [15:0]   icount_q, icount_d;
  logic          error_q,  error_d;
  logic          is_mvi_q, is_mvi_d;

  // Fetch datapath
  logic          load_en;
  logic          do_fetch;
  logic [AW-1:0] fetch_addr;
  logic [15:0]   fetch_word;
  logic [2:0]    fetch_op;
  logic [AW:0]   next_pc;

`ifdef WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT > 0);
`endif

  // Writes are accepted only while the sequencer is not running a program
  assign load_en = load_we && !busy_q;

  // Program RAM write port
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Next-state logic: sequencing, fetch decision and registered output values
  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    run_d      = 1'b0;
    pc_d       = pc_q;
    icount_d   = icount_q;
    error_d    = error_q;
    is_mvi_d   = is_mvi_q;
    do_fetch   = 1'b0;
    fetch_addr = pc_q;
    next_pc    = '0;
`ifdef WATCHDOG_EN
    wd_cnt_d   = wd_cnt_q;
`endif

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d       = '0;
          icount_d   = '0;
          error_d    = 1'b0;
          do_fetch   = 1'b1;
          fetch_addr = '0;
        end
      end

      S_ISSUE: begin
        if (is_mvi_q) begin
          din_d   = mem_q[pc_q + AW'(1)];
          state_d = S_IMM;
        end else begin
          state_d = S_WAIT;
        end
`ifdef WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end

      S_IMM: begin
        state_d = S_WAIT;
`ifdef WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end

      S_WAIT: begin
        if (bus.Done) begin
          icount_d = icount_q + 16'd1;
          next_pc  = {1'b0, pc_q} + (is_mvi_q ? STEP_TWO : STEP_ONE);
          if (next_pc[AW]) begin
            state_d = S_HALT;
          end else begin
            do_fetch   = 1'b1;
            fetch_addr = next_pc[AW-1:0];
          end
        end
`ifdef WATCHDOG_EN
        else if (wd_cnt_q == WD_LAST) begin
          state_d = S_HALT;
          error_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + WDW'(1);
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A write landing on the same edge as a start must be visible to the fetch
    fetch_word = (load_en && (load_addr == fetch_addr)) ? load_data : mem_q[fetch_addr];
    fetch_op   = fetch_word[8:6];

    if (do_fetch) begin
      if (fetch_op == OP_HALT) begin
        state_d = S_HALT;
      end else if ((fetch_op == OP_MVI) && (fetch_addr == LAST_ADR)) begin
        state_d = S_HALT;
        error_d = 1'b1;
      end else begin
        din_d    = fetch_word;
        run_d    = 1'b1;
        pc_d     = fetch_addr;
        is_mvi_d = (fetch_op == OP_MVI);
        state_d  = S_ISSUE;
      end
    end

    if (state_d == S_HALT) begin
      din_d = '0;
    end

    busy_d   = (state_d == S_ISSUE) || (state_d == S_IMM) || (state_d == S_WAIT);
    halted_d = (state_d == S_HALT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      din_q    <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      pc_q     <= '0;
      icount_q <= '0;
      error_q  <= 1'b0;
      is_mvi_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      pc_q     <= pc_d;
      icount_q <= icount_d;
      error_q  <= error_d;
      is_mvi_q <= is_mvi_d;
    end
  end

`ifdef WATCHDOG_EN
  // WAIT-cycle watchdog counter
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`endif

  assign bus.DIN = din_q;
  assign bus.Run = run_q;
  assign busy    = busy_q;
  assign halted  = halted_q;
  assign pc      = pc_q;
  assign icount  = icount_q;
  assign error   = error_q;

endmodule

// File: tb/tb_instr_feeder.sv
// tb_instr_feeder: table-driven bench for instr_feeder.
// Each vector row holds the inputs applied before a rising edge and the
// outputs expected just after it; a few hand-written sequences cover the
// asynchronous reset and the long-wait behaviour.
module tb_instr_feeder;
  localparam int AW = 4;

  logic          clk       = 1'b0;
  logic          Resetn    = 1'b0;
  logic          start     = 1'b0;
  logic          load_we   = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [15:0]   load_data = '0;
  logic          busy;
  logic          halted;
  logic [AW-1:0] pc;
  logic [15:0]   icount;
  logic          error;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [15:0] prog [16];

  typedef struct {
    logic          start;
    logic          done;
    logic          we;
    logic [AW-1:0] waddr;
    logic [15:0]   wdata;
    logic          run;
    logic [15:0]   din;
    logic          busy;
    logic          halted;
    logic [AW-1:0] pc;
    logic [15:0]   icount;
    logic          err;
  } vec_t;

  vec_t vecs[$];

  instr_feeder_if bus();

  instr_feeder #(.AW(AW), .TIMEOUT(8)) dut (
    .clk       (clk),
    .Resetn    (Resetn),
    .start     (start),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data),
    .bus       (bus),
    .busy      (busy),
    .halted    (halted),
    .pc        (pc),
    .icount    (icount),
    .error     (error)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic d, input logic we,
                               input logic [AW-1:0] wa, input logic [15:0] wd);
    start     = s;
    bus.Done  = d;
    load_we   = we;
    load_addr = wa;
    load_data = wd;
  endtask

  task automatic checkField(input string name, input string field,
                            input logic [15:0] got, input logic [15:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s %s: got %h expected %h", name, field, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic r, input logic [15:0] dn,
                             input logic b, input logic h, input logic [AW-1:0] p,
                             input logic [15:0] ic, input logic e);
    checkField(name, "Run",    16'(bus.Run), 16'(r));
    checkField(name, "DIN",    bus.DIN,      dn);
    checkField(name, "busy",   16'(busy),    16'(b));
    checkField(name, "halted", 16'(halted),  16'(h));
    checkField(name, "pc",     16'(pc),      16'(p));
    checkField(name, "icount", icount,       ic);
    checkField(name, "error",  16'(error),   16'(e));
  endtask

  task automatic addVec(input logic s, input logic d, input logic we,
                        input logic [AW-1:0] wa, input logic [15:0] wd,
                        input logic r, input logic [15:0] dn, input logic b,
                        input logic h, input logic [AW-1:0] p,
                        input logic [15:0] ic, input logic e);
    vec_t v;
    v.start  = s;
    v.done   = d;
    v.we     = we;
    v.waddr  = wa;
    v.wdata  = wd;
    v.run    = r;
    v.din    = dn;
    v.busy   = b;
    v.halted = h;
    v.pc     = p;
    v.icount = ic;
    v.err    = e;
    vecs.push_back(v);
  endtask

  task automatic runVectors(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].start, vecs[i].done, vecs[i].we, vecs[i].waddr, vecs[i].wdata);
      tick();
      checkOutput($sformatf("%s[%0d]", name, i), vecs[i].run, vecs[i].din, vecs[i].busy,
                  vecs[i].halted, vecs[i].pc, vecs[i].icount, vecs[i].err);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    vecs.delete();
  endtask

  task automatic loadProg;
    load_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_addr = AW'(i);
      load_data = prog[i];
      tick();
    end
    load_we = 1'b0;
  endtask

  task automatic setProg1;
    for (int i = 0; i < 16; i++) prog[i] = 16'h01C0;
    prog[0] = 16'h0040;
    prog[1] = 16'hAAAA;
    prog[2] = 16'h0008;
    prog[3] = 16'h01C0;
  endtask

  // mvi/imm, mv, halt; noisy variant adds busy-time writes and a Done in HALT
  task automatic fillProg1(input logic noisy);
    addVec(1, 0, 0,      '0,      16'h0000, 1, 16'h0040, 1, 0, 0, 16'd0, 0);
    addVec(0, 0, noisy,  AW'(2),  16'h01C0, 0, 16'hAAAA, 1, 0, 0, 16'd0, 0);
    addVec(0, 0, noisy,  AW'(3),  16'h0000, 0, 16'hAAAA, 1, 0, 0, 16'd0, 0);
    addVec(0, 1, 0,      '0,      16'h0000, 1, 16'h0008, 1, 0, 2, 16'd1, 0);
    addVec(0, 0, 0,      '0,      16'h0000, 0, 16'h0008, 1, 0, 2, 16'd1, 0);
    addVec(0, 0, 0,      '0,      16'h0000, 0, 16'h0008, 1, 0, 2, 16'd1, 0);
    addVec(0, 1, 0,      '0,      16'h0000, 0, 16'h0000, 0, 1, 2, 16'd2, 0);
    addVec(0, noisy, 0,  '0,      16'h0000, 0, 16'h0000, 0, 1, 2, 16'd2, 0);
  endtask

  initial begin
    bus.Done = 1'b0;

    // Reset values
    tick();
    tick();
    checkOutput("reset", 0, 16'h0000, 0, 0, 0, 16'd0, 0);
    Resetn = 1'b1;
    tick();

    // Test 1: mvi + immediate, mv, halt
    setProg1();
    loadProg();
    fillProg1(1'b0);
    runVectors("prog1");

    // Test 2: add then sub, Done three cycles after each Run, zero-bubble reissue
    for (int i = 0; i < 16; i++) prog[i] = 16'h01C0;
    prog[0] = 16'h0081;
    prog[1] = 16'h00C1;
    loadProg();
    addVec(1, 0, 0, '0, 16'h0, 1, 16'h0081, 1, 0, 0, 16'd0, 0);
    addVec(0, 0, 0, '0, 16'h0, 0, 16'h0081, 1, 0, 0, 16'd0, 0);
    addVec(0, 0, 0, '0, 16'h0, 0, 16'h0081, 1, 0, 0, 16'd0, 0);
    addVec(0, 1, 0, '0, 16'h0, 1, 16'h00C1, 1, 0, 1, 16'd1, 0);
    addVec(0, 0, 0, '0, 16'h0, 0, 16'h00C1, 1, 0, 1, 16'd1, 0);
    addVec(0, 0, 0, '0, 16'h0, 0, 16'h00C1, 1, 0, 1, 16'd1, 0);
    addVec(0, 1, 0, '0, 16'h0, 0, 16'h0000, 0, 1, 1, 16'd2, 0);
    runVectors("addsub");

    // Test 3: fifteen mv words then an mvi in the last address
    for (int i = 0; i < 15; i++) prog[i] = 16'h0008;
    prog[15] = 16'h0040;
    loadProg();
    addVec(1, 0, 0, '0, 16'h0, 1, 16'h0008, 1, 0, 0, 16'd0, 0);
    for (int i = 0; i < 15; i++) begin
      addVec(0, 0, 0, '0, 16'h0, 0, 16'h0008, 1, 0, AW'(i), 16'(i), 0);
      if (i < 14)
        addVec(0, 1, 0, '0, 16'h0, 1, 16'h0008, 1, 0, AW'(i + 1), 16'(i + 1), 0);
      else
        addVec(0, 1, 0, '0, 16'h0, 0, 16'h0000, 0, 1, AW'(14), 16'd15, 1);
    end
    addVec(0, 0, 0, '0, 16'h0, 0, 16'h0000, 0, 1, AW'(14), 16'd15, 1);
    runVectors("mvi_at_end");

    // Test 5: writes while busy are dropped, Done in HALT ignored, start clears error
    setProg1();
    loadProg();
    fillProg1(1'b1);
    runVectors("busy_writes");
    fillProg1(1'b0);
    runVectors("rerun_readback");

    // Test 4: asynchronous reset in the middle of the second instruction
    applyStimulus(1, 0, 0, '0, 16'h0);
    tick();
    applyStimulus(0, 0, 0, '0, 16'h0);
    tick();
    tick();
    applyStimulus(0, 1, 0, '0, 16'h0);
    tick();
    applyStimulus(0, 0, 0, '0, 16'h0);
    tick();
    checkOutput("pre_reset_wait", 0, 16'h0008, 1, 0, 2, 16'd1, 0);
    #2;
    Resetn = 1'b0;
    #1;
    checkOutput("async_reset", 0, 16'h0000, 0, 0, 0, 16'd0, 0);
    @(negedge clk);
    Resetn = 1'b1;
    applyStimulus(0, 1, 0, '0, 16'h0);
    tick();
    checkOutput("done_in_idle", 0, 16'h0000, 0, 0, 0, 16'd0, 0);
    applyStimulus(0, 0, 0, '0, 16'h0);
    fillProg1(1'b0);
    runVectors("after_reset");

    // Test 6: Done never arrives
    applyStimulus(1, 0, 0, '0, 16'h0);
    tick();
    applyStimulus(0, 0, 0, '0, 16'h0);
`ifdef WATCHDOG_EN
    repeat (9) tick();
    checkOutput("wd_before_trip", 0, 16'hAAAA, 1, 0, 0, 16'd0, 0);
    tick();
    checkOutput("wd_trip", 0, 16'h0000, 0, 1, 0, 16'd0, 1);
`else
    repeat (100) tick();
    checkOutput("wait_forever", 0, 16'hAAAA, 1, 0, 0, 16'd0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
